// File: rtl/relu_maxpool2x2.sv
// relu_maxpool2x2: ReLU then 2x2 stride-2 max pooling on the conv stream.
// Two-stage pipeline with a half-width row buffer holding even-row maxima.
module relu_maxpool2x2 #(
  parameter int IMG_W = 1920
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] conv_out,
  input  logic        conv_valid,
  input  logic [10:0] x_regcc,
  input  logic [9:0]  y_regcc,
  output logic [19:0] pool_out,
  output logic        pool_valid,
  output logic [9:0]  pool_x,
  output logic [8:0]  pool_y
);

  localparam int ROW_DEPTH = IMG_W / 2;
  localparam int AW = (ROW_DEPTH > 1) ? $clog2(ROW_DEPTH) : 1;
  localparam logic [11:0] W_LIM = 12'(IMG_W);

  logic [28:0] row_buf [ROW_DEPTH];
  logic [28:0] rd_data_q;

  logic          acc;
  logic          pair;
  logic [19:0]   r;
  logic [19:0]   hmax;
  logic [19:0]   smax;
  logic          we;
  logic          re;
  logic [AW-1:0] addr;

  logic        h_ok_q, h_ok_d;
  logic [19:0] h_val_q, h_val_d;
  logic [9:0]  h_x_q, h_x_d;
  logic [9:0]  h_y_q, h_y_d;
  logic        arm_ok_q, arm_ok_d;
  logic [8:0]  arm_pair_q, arm_pair_d;
  logic        s1_vld_q, s1_vld_d;
  logic [19:0] s1_hmax_q, s1_hmax_d;
  logic [9:0]  s1_px_q, s1_px_d;
  logic [8:0]  s1_py_q, s1_py_d;
  logic [19:0] pool_out_q, pool_out_d;
  logic        pool_valid_q, pool_valid_d;
  logic [9:0]  pool_x_q, pool_x_d;
  logic [8:0]  pool_y_q, pool_y_d;

  assign addr = x_regcc[AW:1];

  // Horizontal pairing, row-buffer control and output compare.
  always_comb begin
    h_ok_d       = h_ok_q;
    h_val_d      = h_val_q;
    h_x_d        = h_x_q;
    h_y_d        = h_y_q;
    arm_ok_d     = arm_ok_q;
    arm_pair_d   = arm_pair_q;
    s1_vld_d     = 1'b0;
    s1_hmax_d    = s1_hmax_q;
    s1_px_d      = s1_px_q;
    s1_py_d      = s1_py_q;
    pool_out_d   = pool_out_q;
    pool_valid_d = 1'b0;
    pool_x_d     = pool_x_q;
    pool_y_d     = pool_y_q;
    we           = 1'b0;
    re           = 1'b0;

    acc  = conv_valid && ({1'b0, x_regcc} < W_LIM);
    r    = conv_out[19] ? '0 : conv_out;
    hmax = (h_val_q > r) ? h_val_q : r;
    pair = acc && x_regcc[0] && h_ok_q
        && (h_x_q == x_regcc[10:1])
        && (h_y_q == y_regcc);

    if (acc && !x_regcc[0]) begin
      h_ok_d  = 1'b1;
      h_val_d = r;
      h_x_d   = x_regcc[10:1];
      h_y_d   = y_regcc;
    end
    if (acc && x_regcc[0]) begin
      h_ok_d = 1'b0;
    end

    if (pair && !y_regcc[0]) begin
      we         = 1'b1;
      arm_ok_d   = 1'b1;
      arm_pair_d = y_regcc[9:1];
    end
    if (pair && y_regcc[0]) begin
      re        = 1'b1;
      s1_vld_d  = arm_ok_q && (arm_pair_q == y_regcc[9:1]);
      s1_hmax_d = hmax;
      s1_px_d   = x_regcc[10:1];
      s1_py_d   = y_regcc[9:1];
    end

    smax = (rd_data_q[19:0] > s1_hmax_q)
         ? rd_data_q[19:0] : s1_hmax_q;
    if (s1_vld_q && (rd_data_q[28:20] == s1_py_q)) begin
      pool_valid_d = 1'b1;
      pool_out_d   = smax;
      pool_x_d     = s1_px_q;
      pool_y_d     = s1_py_q;
    end
  end

  // Control and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_ok_q       <= 1'b0;
      h_val_q      <= '0;
      h_x_q        <= '0;
      h_y_q        <= '0;
      arm_ok_q     <= 1'b0;
      arm_pair_q   <= '0;
      s1_vld_q     <= 1'b0;
      s1_hmax_q    <= '0;
      s1_px_q      <= '0;
      s1_py_q      <= '0;
      pool_out_q   <= '0;
      pool_valid_q <= 1'b0;
      pool_x_q     <= '0;
      pool_y_q     <= '0;
    end else begin
      h_ok_q       <= h_ok_d;
      h_val_q      <= h_val_d;
      h_x_q        <= h_x_d;
      h_y_q        <= h_y_d;
      arm_ok_q     <= arm_ok_d;
      arm_pair_q   <= arm_pair_d;
      s1_vld_q     <= s1_vld_d;
      s1_hmax_q    <= s1_hmax_d;
      s1_px_q      <= s1_px_d;
      s1_py_q      <= s1_py_d;
      pool_out_q   <= pool_out_d;
      pool_valid_q <= pool_valid_d;
      pool_x_q     <= pool_x_d;
      pool_y_q     <= pool_y_d;
    end
  end

  // Row buffer: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      row_buf[addr] <= {y_regcc[9:1], hmax};
    end
    if (re) begin
      rd_data_q <= row_buf[addr];
    end
  end

  assign pool_out   = pool_out_q;
  assign pool_valid = pool_valid_q;
  assign pool_x     = pool_x_q;
  assign pool_y     = pool_y_q;

endmodule
